// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: forwarding select encodings, the
// multiply/divide latency default and the register-match helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned MD_LATENCY_DEF = 32;
  localparam int unsigned MD_CNT_W       = 6;
  localparam int unsigned PERF_CNT_W     = 32;

  // r0 is hard-wired to zero, so a write to it never produces a dependency.
  function automatic logic reg_hit(input logic [4:0] src,
                                   input logic       wr_en,
                                   input logic [4:0] dst);
    return wr_en && (src != 5'd0) && (src == dst);
  endfunction

  function automatic fwd_sel_e ex_fwd(input logic [4:0] src,
                                      input logic       wr_m,
                                      input logic [4:0] dst_m,
                                      input logic       wr_w,
                                      input logic [4:0] dst_w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (reg_hit(src, wr_m, dst_m)) begin
      sel = FWD_MEM;
    end else if (reg_hit(src, wr_w, dst_w)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide occupancy timer: a down-counter loaded with LATENCY-1 on
// start; busy while the count is nonzero. A new start restarts the count.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(LATENCY - 1);

  logic [MD_CNT_W-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= LOAD_VAL;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_CNT_W'(1);
    end
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX/ID forwarding, load-use, branch and mult/div stalls.
// Optional saturating stall/flush counters when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        MdUseD,
  input  logic        MdStartE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
`endif
  output logic        MdBusy
);

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;
  logic md_busy;

  md_busy_cnt #(
    .LATENCY (MD_LATENCY)
  ) u_md_busy_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (MdStartE),
    .busy  (md_busy)
  );

  assign MdBusy = md_busy;

  // Forwarding is purely a function of register fields; the stall state never gates it.
  always_comb begin
    ForwardAE = ex_fwd(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardBE = ex_fwd(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardAD = reg_hit(RsD, RegWriteM, WriteRegM);
    ForwardBD = reg_hit(RtD, RegWriteM, WriteRegM);
  end

  always_comb begin
    lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));

    // A branch resolves in ID, so it waits on an ALU result still in EX or a load still in MEM.
    brstall = BranchD &&
              (reg_hit(RsD, RegWriteE, WriteRegE) ||
               reg_hit(RtD, RegWriteE, WriteRegE) ||
               reg_hit(RsD, MemtoRegM, WriteRegM) ||
               reg_hit(RtD, MemtoRegM, WriteRegM));

    // MdStartE covers the cycle the counter is being loaded but not yet busy.
    mdstall = MdUseD && (md_busy || MdStartE);

    stall = lwstall || brstall || mdstall;
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
      end
      if (brstall && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
      end
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a cycle-level
// behavioural model, plus directed cases with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int MD_LAT = 32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        BranchD, MdUseD, MdStartE;
  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0]  ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int tests  = 0;
  int failed = 0;

  // Model: the mult/div is tracked by the edge number at which it started.
  bit          md_active   = 0;
  int          md_start_ed = 0;
  int          edge_cnt    = 0;
  logic [31:0] m_stall_cnt = 0;
  logic [31:0] m_flush_cnt = 0;

  hazard_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .MdUseD    (MdUseD),
    .MdStartE  (MdStartE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
`ifdef HAZARD_PERF_CNT_EN
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt),
`endif
    .MdBusy    (MdBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
    if (src != 0 && RegWriteM && WriteRegM == src) return 2'b10;
    if (src != 0 && RegWriteW && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_fwd_d(input logic [4:0] src);
    return (src != 0) && RegWriteM && (WriteRegM == src);
  endfunction

  function automatic logic m_busy();
    int k;
    k = edge_cnt - md_start_ed;
    return md_active && (k >= 1) && (k <= MD_LAT - 1);
  endfunction

  function automatic logic m_br();
    logic e_dep, m_dep;
    e_dep = RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    m_dep = MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD);
    return BranchD && (e_dep || m_dep);
  endfunction

  function automatic logic m_stall();
    logic lw, md;
    lw = MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
    md = MdUseD && (m_busy() || MdStartE);
    return lw || m_br() || md;
  endfunction

  task automatic check_all();
    logic s;
    s = m_stall();
    chk("StallF", StallF, s);
    chk("StallD", StallD, s);
    chk("FlushE", FlushE, s);
    chk("ForwardAE", ForwardAE, m_fwd_e(RsE));
    chk("ForwardBE", ForwardBE, m_fwd_e(RtE));
    chk("ForwardAD", ForwardAD, m_fwd_d(RsD));
    chk("ForwardBD", ForwardBD, m_fwd_d(RtD));
    chk("MdBusy", MdBusy, m_busy());
`ifdef HAZARD_PERF_CNT_EN
    chk("StallCnt", StallCnt, m_stall_cnt);
    chk("FlushCnt", FlushCnt, m_flush_cnt);
`endif
  endtask

  // Advance one clock edge and update the model from the inputs sampled there.
  task automatic tick();
    logic s, b;
    s = m_stall();
    b = m_br();
    @(posedge clk);
    if (!rst_n) begin
      md_active   = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (s && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
      if (b && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 1;
      if (MdStartE) begin
        md_active   = 1;
        md_start_ed = edge_cnt;
      end
    end
    edge_cnt++;
    #1;
  endtask

  task automatic step();
    #1;
    check_all();
    tick();
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; MdUseD = 0; MdStartE = 0;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, "_StallF"}, StallF, exp);
    chk({name, "_StallD"}, StallD, exp);
    chk({name, "_FlushE"}, FlushE, exp);
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    // All inputs zero during reset: every output zero.
    chk_stall("rst", 1'b0);
    chk("rst_ForwardAE", ForwardAE, 2'b00);
    chk("rst_ForwardBE", ForwardBE, 2'b00);
    chk("rst_ForwardAD", ForwardAD, 1'b0);
    chk("rst_ForwardBD", ForwardBD, 1'b0);
    chk("rst_MdBusy", MdBusy, 1'b0);
    rst_n = 1;
    step();

    // EX forwarding, MEM priority, r0 exclusion.
    RsE = 5; RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5;
    #1 chk("fwdA_mem", ForwardAE, 2'b10);
    RsE = 0;
    #1 chk("fwdA_r0", ForwardAE, 2'b00);
    step();
    clear_inputs();
    RtE = 7; RegWriteM = 1; WriteRegM = 7; RegWriteW = 1; WriteRegW = 7;
    #1 chk("fwdB_mem_wins", ForwardBE, 2'b10);
    RegWriteM = 0;
    #1 chk("fwdB_wb", ForwardBE, 2'b01);
    step();

    // Load-use stall for exactly one cycle; RtE=0 never stalls.
    clear_inputs();
    MemtoRegE = 1; RtE = 8; RsD = 8;
    #1 chk_stall("lw", 1'b1);
    step();
    clear_inputs();
    #1 chk_stall("lw_next", 1'b0);
    MemtoRegE = 1; RtE = 0; RsD = 0;
    #1 chk_stall("lw_r0", 1'b0);
    step();

    // Branch waits on EX producer, then bypasses from MEM.
    clear_inputs();
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    #1 chk_stall("br_ex", 1'b1);
    step();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3; MemtoRegM = 0;
    #1 chk_stall("br_mem", 1'b0);
    chk("br_ForwardAD", ForwardAD, 1'b1);
    step();

    // Mult/div: 31 busy cycles, mfhi stalls through md_cnt==1.
    clear_inputs();
    MdStartE = 1; MdUseD = 1;
    #1 chk("md_start_StallD", StallD, 1'b1);
    step();
    MdStartE = 0;
    for (int i = 0; i < 31; i++) begin
      #1;
      chk("md_busy", MdBusy, 1'b1);
      chk("md_stall", StallD, 1'b1);
      step();
    end
    #1;
    chk("md_done_busy", MdBusy, 1'b0);
    chk("md_done_stall", StallD, 1'b0);
    step();

    // Reset at cycle 10 of a mult/div aborts it.
    clear_inputs();
    MdStartE = 1;
    step();
    MdStartE = 0;
    repeat (9) step();
    rst_n = 0; MdUseD = 1;
    step();
    rst_n = 1;
    #1;
    chk("md_rst_busy", MdBusy, 1'b0);
    chk("md_rst_stall", StallD, 1'b0);
    step();

`ifdef HAZARD_PERF_CNT_EN
    clear_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    #1 chk("perf_rst_stall", StallCnt, 32'd0);
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step();
    step();
    clear_inputs();
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    step();
    clear_inputs();
    #1;
    chk("perf_stall3", StallCnt, 32'd3);
    chk("perf_flush1", FlushCnt, 32'd1);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_stall_cnt = 32'hFFFF_FFFF;
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step();
    clear_inputs();
    #1 chk("perf_sat", StallCnt, 32'hFFFF_FFFF);
    step();
`endif

    // Randomized traffic with small register numbers to make matches common.
    for (int n = 0; n < 3000; n++) begin
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      RsE       = 5'($urandom_range(0, 3));
      RtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 1));
      MemtoRegM = 1'($urandom_range(0, 1));
      BranchD   = 1'($urandom_range(0, 1));
      MdUseD    = 1'($urandom_range(0, 1));
      MdStartE  = ($urandom_range(0, 29) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
